// File: rtl/sigbuff_ctrl_if.sv
// sigbuff_ctrl_if
//   Bundles the iteration controller's sigbuff_* command bus, the two sample
//   sources, the FIR-driver output and the status outputs of the signal
//   buffer controller.
//
//   Handshake semantics: there is no ready/backpressure anywhere on this bus.
//   A *_valid input qualifies its data in the same cycle. out_valid marks
//   out_data/out_iter as a fresh sample for exactly that cycle. The buffer
//   accepts every qualified write and performs every strobed read.
//
//   Modports:
//     master - the controller/testbench side, drives commands and samples.
//     slave  - the buffer (sigbuff_ctrl), drives out_* and status.
//
//   Parameters: DATA_WIDTH (sample width), ADDR_WIDTH (RAM address width).
interface sigbuff_ctrl_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
);
    logic [4:0]            iter_num;
    logic                  input_mux;
    logic                  input_enable;
    logic                  output_enable;
    logic [DATA_WIDTH-1:0] lvl_gen_data;
    logic                  lvl_gen_valid;
    logic [DATA_WIDTH-1:0] lim_data;
    logic                  lim_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic [4:0]            out_iter;
    logic                  status_clr;
    logic [ADDR_WIDTH:0]   fill_level;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output iter_num, input_mux, input_enable, output_enable,
        output lvl_gen_data, lvl_gen_valid, lim_data, lim_valid, status_clr,
        input  out_data, out_valid, out_iter, fill_level, overflow, underflow
    );

    modport slave (
        input  iter_num, input_mux, input_enable, output_enable,
        input  lvl_gen_data, lvl_gen_valid, lim_data, lim_valid, status_clr,
        output out_data, out_valid, out_iter, fill_level, overflow, underflow
    );
endinterface

// File: rtl/sigbuff_ctrl.sv
// sigbuff_ctrl
//   Signal buffer controller. Stores one frame of level-crossing samples in
//   an inferred dual-port RAM, written either from the level generator or
//   from the hard-limiter feedback path, and streams the frame to the FIR
//   driver with each sample tagged by its iteration number.
//
//   Ports:
//     clock  - clock
//     reset  - synchronous, active-high reset
//     bus    - sigbuff_ctrl_if.slave: command inputs (iter_num, input_mux,
//              input_enable, output_enable, status_clr), sample sources
//              (lvl_gen_*, lim_*), output stream (out_data, out_valid,
//              out_iter) and status (fill_level, overflow, underflow).
//
//   Parameters:
//     MAX_SAMPLES_IN_RAM - frame length; pointers wrap at this value minus 1
//     DATA_WIDTH         - sample width
//     ADDR_WIDTH         - RAM address width, 2**ADDR_WIDTH >= MAX_SAMPLES_IN_RAM
//
//   Build option: define SIGBUFF_STATUS_EN to compile in the fill counter and
//   the sticky overflow/underflow flags. Without it those outputs are tied
//   to 0 and status_clr is ignored; the data path is unaffected.
module sigbuff_ctrl #(
    parameter int MAX_SAMPLES_IN_RAM = 255,
    parameter int DATA_WIDTH         = 16,
    parameter int ADDR_WIDTH         = 8
) (
    input logic           clock,
    input logic           reset,
    sigbuff_ctrl_if.slave bus
);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(MAX_SAMPLES_IN_RAM - 1);
    localparam logic [ADDR_WIDTH:0]   FULL_LEVEL = (ADDR_WIDTH + 1)'(MAX_SAMPLES_IN_RAM);

    // Frame length need not be a power of two, so wrap explicitly.
    function automatic logic [ADDR_WIDTH-1:0] next_ptr(input logic [ADDR_WIDTH-1:0] p);
        return (p == LAST_ADDR) ? '0 : p + 1'b1;
    endfunction

    logic                  src_valid;
    logic [DATA_WIDTH-1:0] src_data;
    logic                  wr_en;
    logic                  rd_en;

    always_comb begin
        src_valid = bus.input_mux ? bus.lim_valid : bus.lvl_gen_valid;
        src_data  = bus.input_mux ? bus.lim_data  : bus.lvl_gen_data;
        wr_en     = bus.input_enable & src_valid;
        rd_en     = bus.output_enable;
    end

    logic [DATA_WIDTH-1:0] mem [MAX_SAMPLES_IN_RAM];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;

    // RAM contents are deliberately not reset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_ptr] <= src_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= next_ptr(wr_ptr);
            if (rd_en) rd_ptr <= next_ptr(rd_ptr);
        end
    end

    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  out_valid_q;
    logic [4:0]            out_iter_q;

    // Reads happen whenever strobed, even when empty: the downstream
    // pipeline relies on fixed timing. The registered read sees the RAM
    // before this edge's write, giving read-first behaviour on a collision.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_iter_q  <= '0;
        end else begin
            out_valid_q <= rd_en;
            if (rd_en) begin
                out_data_q <= mem[rd_ptr];
                out_iter_q <= bus.iter_num;
            end
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_iter  = out_iter_q;

`ifdef SIGBUFF_STATUS_EN
    logic [ADDR_WIDTH:0] fill_q;
    logic                overflow_q;
    logic                underflow_q;
    logic                write_only;
    logic                read_only;

    always_comb begin
        write_only = wr_en & ~rd_en;
        read_only  = rd_en & ~wr_en;
    end

    // A simultaneous write and read leaves the level unchanged. A set
    // condition takes priority over status_clr in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            fill_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (write_only && (fill_q != FULL_LEVEL)) begin
                fill_q <= fill_q + 1'b1;
            end else if (read_only && (fill_q != '0)) begin
                fill_q <= fill_q - 1'b1;
            end

            if (write_only && (fill_q == FULL_LEVEL)) begin
                overflow_q <= 1'b1;
            end else if (bus.status_clr) begin
                overflow_q <= 1'b0;
            end

            if (read_only && (fill_q == '0)) begin
                underflow_q <= 1'b1;
            end else if (bus.status_clr) begin
                underflow_q <= 1'b0;
            end
        end
    end

    assign bus.fill_level = fill_q;
    assign bus.overflow   = overflow_q;
    assign bus.underflow  = underflow_q;
`else
    logic unused_status_clr;

    assign unused_status_clr = bus.status_clr;
    assign bus.fill_level    = '0;
    assign bus.overflow      = 1'b0;
    assign bus.underflow     = 1'b0;
`endif

endmodule

// File: tb/tb_sigbuff_ctrl.sv
// tb_sigbuff_ctrl
//   Self-checking bench for sigbuff_ctrl. A behavioural model (array RAM,
//   modulo pointers, integer fill count) predicts every output sample and
//   the per-cycle status. A 5-deep frame is used so that the non power of
//   two wrap and the full/empty boundaries are exercised often.
module tb_sigbuff_ctrl;
  localparam int MAX = 5;
  localparam int DW  = 16;
  localparam int AW  = 3;
  localparam int EW  = 1 + 5 + DW;  // {data_known, iter, data}

`ifdef SIGBUFF_STATUS_EN
  localparam bit STATUS_EN = 1'b1;
`else
  localparam bit STATUS_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  sigbuff_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  sigbuff_ctrl #(
    .MAX_SAMPLES_IN_RAM(MAX),
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;
  int n_checks = 0;
  int n_fail   = 0;

  // reference model
  logic [DW-1:0] m_mem[MAX];
  bit            m_known[MAX];
  int            m_wr, m_rd, m_fill;
  bit            m_ovf, m_unf;
  bit            m_out_valid;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Drives one cycle of inputs, advances the model, waits for the edge and
  // checks the cycle-exact outputs. Output samples go through exp_q.
  task automatic drive(input bit rst, input bit mux, input bit en,
                       input bit lvl_v, input logic [DW-1:0] lvl_d,
                       input bit lim_v, input logic [DW-1:0] lim_d,
                       input bit oe, input bit clr, input logic [4:0] iter);
    bit            src_v, wr, ovf_set, unf_set;
    logic [DW-1:0] src_d;
    reset             = rst;
    bus.input_mux     = mux;
    bus.input_enable  = en;
    bus.lvl_gen_valid = lvl_v;
    bus.lvl_gen_data  = lvl_d;
    bus.lim_valid     = lim_v;
    bus.lim_data      = lim_d;
    bus.output_enable = oe;
    bus.status_clr    = clr;
    bus.iter_num      = iter;

    src_v = mux ? lim_v : lvl_v;
    src_d = mux ? lim_d : lvl_d;
    wr    = en && src_v;
    if (rst) begin
      m_wr = 0; m_rd = 0; m_fill = 0; m_ovf = 0; m_unf = 0;
      m_out_valid = 0;
    end else begin
      m_out_valid = oe;
      if (oe) begin
        exp_q.push_back({m_known[m_rd], iter, m_mem[m_rd]});
        m_rd = (m_rd + 1) % MAX;
      end
      if (wr) begin
        m_mem[m_wr]   = src_d;
        m_known[m_wr] = 1'b1;
        m_wr = (m_wr + 1) % MAX;
      end
      ovf_set = wr && !oe && (m_fill == MAX);
      unf_set = oe && !wr && (m_fill == 0);
      if (wr && !oe && m_fill < MAX) m_fill++;
      if (oe && !wr && m_fill > 0)   m_fill--;
      m_ovf = ovf_set ? 1'b1 : (clr ? 1'b0 : m_ovf);
      m_unf = unf_set ? 1'b1 : (clr ? 1'b0 : m_unf);
    end

    @(posedge clock);
    #1;
    check("out_valid", bus.out_valid, m_out_valid);
    check("fill_level", bus.fill_level, STATUS_EN ? m_fill : 0);
    check("overflow", bus.overflow, STATUS_EN ? m_ovf : 0);
    check("underflow", bus.underflow, STATUS_EN ? m_unf : 0);
  endtask

  task automatic wr_sample(input logic [DW-1:0] d);
    drive(0, 0, 1, 1, d, 0, DW'($urandom), 0, 0, 5'($urandom));
  endtask

  task automatic rd_sample(input logic [4:0] iter = 5'($urandom));
    drive(0, 0, 0, 0, '0, 0, '0, 1, 0, iter);
  endtask

  task automatic idle(input bit clr = 0);
    drive(0, 0, 0, 0, '0, 0, '0, 0, clr, 5'($urandom));
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, '0, 0, '0, 0, 0, '0);
    check("reset_out_data", bus.out_data, 0);
    check("reset_out_iter", bus.out_iter, 0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (bus.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e[EW-1]) check("out_data", bus.out_data, mon_e[DW-1:0]);
        check("out_iter", bus.out_iter, mon_e[DW+4:DW]);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 2000000");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    bit rst_r, mux_r, en_r, lv_r, mv_r, oe_r, clr_r;
    for (int i = 0; i < MAX; i++) m_known[i] = 1'b0;
    bus.iter_num = '0; bus.input_mux = 0; bus.input_enable = 0;
    bus.output_enable = 0; bus.lvl_gen_data = '0; bus.lvl_gen_valid = 0;
    bus.lim_data = '0; bus.lim_valid = 0; bus.status_clr = 0;
    @(posedge clock);
    #1;
    do_reset(3);

    // basic round trip
    wr_sample(16'h0011); wr_sample(16'h0022); wr_sample(16'h0033);
    rd_sample(); rd_sample(); rd_sample();
    idle(); idle();

    // source select: limiter chosen over level generator, then two
    // cycles where only the unselected source is valid (no write)
    drive(0, 1, 1, 1, 16'h0123, 1, 16'h0ABC, 0, 0, 5'd3);
    rd_sample(5'd4);
    drive(0, 0, 1, 0, 16'h5555, 1, 16'h6666, 0, 0, 5'd5);
    drive(0, 1, 1, 1, 16'h7777, 0, 16'h8888, 0, 0, 5'd6);
    idle(1);

    // wrap and overflow
    do_reset(1);
    for (int i = 1; i <= MAX + 1; i++) wr_sample(DW'(i));
    for (int i = 0; i < MAX; i++) rd_sample();
    idle(); idle(1); idle();

    // read-during-write on the same address
    do_reset(1);
    wr_sample(16'h0007); rd_sample();
    for (int i = 1; i < MAX; i++) wr_sample(DW'(16'h0100 + i));
    for (int i = 1; i < MAX; i++) rd_sample();
    drive(0, 0, 1, 1, 16'h0009, 0, '0, 1, 0, 5'd9);
    for (int i = 1; i < MAX; i++) wr_sample(DW'(16'h0200 + i));
    for (int i = 0; i < MAX; i++) rd_sample();
    idle(1); idle();

    // underflow then clear; then set and clear in the same cycle
    do_reset(1);
    rd_sample(5'd17);
    idle(); idle(1); idle();
    drive(0, 0, 0, 0, '0, 0, '0, 1, 1, 5'd21);
    idle(1); idle();

    // reset mid-stream
    do_reset(1);
    for (int i = 0; i < 4; i++) wr_sample(DW'(16'hA000 + i));
    rd_sample(); rd_sample();
    drive(1, 0, 0, 0, '0, 0, '0, 1, 0, 5'd1);
    rd_sample(); rd_sample();
    idle();

    // randomized traffic
    for (int c = 0; c < 800; c++) begin
      rst_r = ($urandom_range(0, 79) == 0);
      mux_r = 1'($urandom);
      en_r  = rst_r ? 1'b0 : ($urandom_range(0, 3) != 0);
      lv_r  = ($urandom_range(0, 3) != 0);
      mv_r  = ($urandom_range(0, 3) != 0);
      oe_r  = ($urandom_range(0, 2) != 0);
      clr_r = ($urandom_range(0, 9) == 0);
      drive(rst_r, mux_r, en_r, lv_r, DW'($urandom), mv_r, DW'($urandom),
            oe_r, clr_r, 5'($urandom));
    end

    idle(); idle(); idle();
    check("expected_queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
